multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the RV32 subset core: lh, sh, add, or, sll, andi, bne.
- Sequences each instruction through fetch, decode, execute, memory and writeback over a shared single-port memory.
- Drives the ALU-control stage through alu_op and steers PC, IR, register-file and memory enables.
- Tracks a per-access memory timeout counter and reports an illegal opcode as a sticky fault.

---
 rtl/core_pkg.sv | 136 +++++++++++++
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl_mem_timeout.sv | 50 +++++
 rtl/multicycle_ctrl.sv | 112 +++++++++++
 tb/tb_multicycle_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the multicycle RV32-subset core.
// Holds the control FSM state enum, the opcode/funct3 constants of the
// supported instructions (lh, sh, add, or, sll, andi, bne), the alu_op and
// alu_src_b encodings (the ALU-control stage uses the same alu_op values)
// and the per-state control-word decode used by multicycle_ctrl.
package core_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WR   = 4'd4,
    ST_WB_MEM   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_ILLEGAL  = 4'd10,
    ST_HALT     = 4'd11
  } state_t;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 values that select the supported member of each opcode group
  localparam logic [2:0] F3_HALF = 3'b001;  // lh / sh
  localparam logic [2:0] F3_AND  = 3'b111;  // andi
  localparam logic [2:0] F3_NE   = 3'b001;  // bne

  // alu_op encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // alu_src_b encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Moore control word. ir_write/pc_write are not in here: they are only
  // asserted in FETCH while the memory acknowledges.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Control word for a state; anything not set stays 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      ST_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
      end
      ST_DECODE: begin
        // PC + imm: branch target precomputed into ALUOut
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_AND;
      end
      ST_WB_ALU: begin
        c.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RS2;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      default: c = CTRL_IDLE;  // ILLEGAL and HALT drive nothing
    endcase
    return c;
  endfunction

  // DECODE dispatch on the latched instruction.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
    state_t s;
    s = ST_ILLEGAL;
    case (op)
      OP_LOAD:   if (f3 == F3_HALF) s = ST_MEM_ADDR;
      OP_STORE:  if (f3 == F3_HALF) s = ST_MEM_ADDR;
      OP_RTYPE:  s = ST_EXEC_R;  // add/or/sll: funct3 goes to ALU control
      OP_ITYPE:  if (f3 == F3_AND) s = ST_EXEC_I;
      OP_BRANCH: if (f3 == F3_NE) s = ST_BRANCH;
      default:   s = ST_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multicycle control FSM and
// the datapath / memory.
//   master (controller): inputs opcode, funct3, mem_ready;
//                        outputs memory, PC/IR, ALU and register-file
//                        controls plus the sticky fault flag.
//   slave  (datapath):   the mirror image.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;
  logic       fault;

  modport master (
    input  opcode, funct3, mem_ready,
    output mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           fault
  );

  modport slave (
    output opcode, funct3, mem_ready,
    input  mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           fault
  );
endinterface

// File: rtl/multicycle_ctrl_mem_timeout.sv
// mem_timeout: per-access memory wait counter.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   mem_req     a memory access is being requested this cycle
//   mem_ready   memory acknowledges this cycle
//   expire      this cycle is the MEM_TIMEOUT-th un-acknowledged cycle of
//               the current access (never set while mem_ready=1)
// Parameters: MEM_TIMEOUT (0 disables), TO_W counter width.
module mem_timeout #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic expire
);

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam logic [TO_W:0] LIMIT = (TO_W + 1)'(MEM_TIMEOUT);

      logic [TO_W-1:0] count_reg;
      logic [TO_W:0]   count_next;

      // One extra bit so the compare cannot wrap.
      assign count_next = {1'b0, count_reg} + (TO_W + 1)'(1);

      // Firing on count_next lets the FSM leave on the same edge the count
      // would reach the limit; mem_ready masks it so an ack always wins.
      assign expire = mem_req & ~mem_ready & (count_next >= LIMIT);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (!mem_req || mem_ready || expire) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next[TO_W-1:0];
        end
      end
    end else begin : g_no_timeout
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, mem_req, mem_ready};
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM of the multicycle RV32-subset core
// (lh, sh, add, or, sll, andi, bne). Sequences fetch, decode, execute,
// memory and writeback over a shared single-port memory.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    multicycle_ctrl_if.master: opcode/funct3/mem_ready in; memory,
//          PC/IR, ALU, register-file controls and sticky fault out
// Parameters: MEM_TIMEOUT (cycles before a stalled access faults, 0 = off),
//             TO_W (timeout counter width).
// Build option: define ILLEGAL_TRAP_EN to halt with fault on an illegal
//               instruction; otherwise an illegal instruction is a one-cycle
//               NOP and fetch continues.
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_reg;
  logic   fault_reg;
  logic   expire;
  logic   fetch_ack;

  mem_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_mem_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (ctrl_reg.mem_req),
    .mem_ready (bus.mem_ready),
    .expire    (expire)
  );

  function automatic state_t next_state(
    input state_t     s,
    input logic [6:0] op,
    input logic [2:0] f3,
    input logic       rdy,
    input logic       to
  );
    state_t n;
    n = s;
    case (s)
      ST_FETCH:    n = rdy ? ST_DECODE : (to ? ST_HALT : ST_FETCH);
      ST_DECODE:   n = decode_next(op, f3);
      ST_MEM_ADDR: n = (op == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   n = rdy ? ST_WB_MEM : (to ? ST_HALT : ST_MEM_RD);
      ST_MEM_WR:   n = rdy ? ST_FETCH : (to ? ST_HALT : ST_MEM_WR);
      ST_WB_MEM:   n = ST_FETCH;
      ST_EXEC_R:   n = ST_WB_ALU;
      ST_EXEC_I:   n = ST_WB_ALU;
      ST_WB_ALU:   n = ST_FETCH;
      ST_BRANCH:   n = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
      ST_ILLEGAL:  n = ST_HALT;
`else
      // PC already advanced in FETCH, so just carry on with the next one.
      ST_ILLEGAL:  n = ST_FETCH;
`endif
      default:     n = ST_HALT;  // HALT is left only through reset
    endcase
    return n;
  endfunction

  assign state_next = next_state(state_reg, bus.opcode, bus.funct3,
                                 bus.mem_ready, expire);

  // Control word is registered from the next state so outputs are glitch-free
  // Moore outputs of the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
      ctrl_reg  <= state_ctrl(ST_FETCH);
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= state_ctrl(state_next);
      // HALT is only ever entered on a fault (timeout or trapped illegal).
      if (state_next == ST_HALT && state_reg != ST_HALT) begin
        fault_reg <= 1'b1;
      end
    end
  end

  // IR latch and PC+4 happen on the cycle the fetch is acknowledged; gating
  // with rst_n keeps them quiet while reset is held.
  assign fetch_ack = rst_n & (state_reg == ST_FETCH) & bus.mem_ready;

  assign bus.mem_req       = ctrl_reg.mem_req;
  assign bus.mem_write     = ctrl_reg.mem_write;
  assign bus.i_or_d        = ctrl_reg.i_or_d;
  assign bus.ir_write      = fetch_ack;
  assign bus.pc_write      = fetch_ack;
  assign bus.pc_write_cond = ctrl_reg.pc_write_cond;
  assign bus.pc_source     = ctrl_reg.pc_source;
  assign bus.alu_src_a     = ctrl_reg.alu_src_a;
  assign bus.alu_src_b     = ctrl_reg.alu_src_b;
  assign bus.alu_op        = ctrl_reg.alu_op;
  assign bus.reg_write     = ctrl_reg.reg_write;
  assign bus.mem_to_reg    = ctrl_reg.mem_to_reg;
  assign bus.fault         = fault_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4).
// Each instruction is expanded into its sequence of phases from its class;
// each phase has an expected output vector, and memory phases get random
// or fixed wait states.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_RTYPE  = 7'b0110011;
  localparam logic [6:0] T_ITYPE  = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MW, P_WBM, P_ER, P_EI, P_WBA,
                    P_BR, P_ILL, P_HALT} phase_e;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  phase_e      plan_q[$];
  logic [14:0] obs_q[$];
  logic [14:0] exp_q[$];
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;

  // {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
  //  pc_source, alu_src_a, alu_src_b[1:0], alu_op[1:0], reg_write,
  //  mem_to_reg, fault}
  function automatic logic [14:0] obs_vec();
    return {bus.mem_req, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
            bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.reg_write, bus.mem_to_reg, bus.fault};
  endfunction

  function automatic logic [14:0] exp_vec(input phase_e p, input logic rdy,
                                          input logic flt);
    logic [14:0] v;
    v = '0;
    case (p)
      P_F:   begin v[14] = 1'b1; v[6:5] = 2'b01;
                   if (rdy) begin v[11] = 1'b1; v[10] = 1'b1; end end
      P_D:   v[6:5] = 2'b10;
      P_MA:  begin v[7] = 1'b1; v[6:5] = 2'b10; end
      P_MR:  begin v[14] = 1'b1; v[12] = 1'b1; end
      P_MW:  begin v[14] = 1'b1; v[13] = 1'b1; v[12] = 1'b1; end
      P_WBM: begin v[2] = 1'b1; v[1] = 1'b1; end
      P_ER:  begin v[7] = 1'b1; v[4:3] = 2'b10; end
      P_EI:  begin v[7] = 1'b1; v[6:5] = 2'b10; v[4:3] = 2'b11; end
      P_WBA: v[2] = 1'b1;
      P_BR:  begin v[9] = 1'b1; v[8] = 1'b1; v[7] = 1'b1; v[4:3] = 2'b01; end
      default: v = '0;
    endcase
    v[0] = flt;
    return v;
  endfunction

  task automatic build_plan(input logic [6:0] op, input logic [2:0] f3);
    plan_q.delete();
    plan_q.push_back(P_F);
    plan_q.push_back(P_D);
    if ((op == T_LOAD) && (f3 == 3'b001)) begin
      plan_q.push_back(P_MA); plan_q.push_back(P_MR); plan_q.push_back(P_WBM);
    end else if ((op == T_STORE) && (f3 == 3'b001)) begin
      plan_q.push_back(P_MA); plan_q.push_back(P_MW);
    end else if (op == T_RTYPE) begin
      plan_q.push_back(P_ER); plan_q.push_back(P_WBA);
    end else if ((op == T_ITYPE) && (f3 == 3'b111)) begin
      plan_q.push_back(P_EI); plan_q.push_back(P_WBA);
    end else if ((op == T_BRANCH) && (f3 == 3'b001)) begin
      plan_q.push_back(P_BR);
    end else begin
      plan_q.push_back(P_ILL);
`ifdef ILLEGAL_TRAP_EN
      plan_q.push_back(P_HALT);
`endif
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, record both.
  task automatic one_cycle(input phase_e p, input logic rdy, input logic flt);
    @(negedge clk);
    rst_n = 1'b1;
    bus.opcode = cur_op;
    bus.funct3 = cur_f3;
    bus.mem_ready = rdy;
    #1;
    obs_q.push_back(obs_vec());
    exp_q.push_back(exp_vec(p, rdy, flt));
  endtask

  // Runs one instruction; wait counts < 0 pick 0..TO-1 at random.
  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3,
                            input int fwait, input int mwait);
    int w;
    logic flt;
    flt = 1'b0;
    cur_op = op;
    cur_f3 = f3;
    build_plan(op, f3);
    foreach (plan_q[i]) begin
      if (plan_q[i] == P_HALT) flt = 1'b1;
      if (plan_q[i] inside {P_F, P_MR, P_MW}) begin
        w = (plan_q[i] == P_F) ? fwait : mwait;
        if (w < 0) w = $urandom_range(0, TO - 1);
        repeat (w) one_cycle(plan_q[i], 1'b0, flt);
        one_cycle(plan_q[i], 1'b1, flt);
      end else begin
        one_cycle(plan_q[i], 1'($urandom_range(0, 1)), flt);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [14:0] o;
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 7'h0;
    bus.funct3 = 3'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      o = obs_vec();
      checks++;
      if (o !== exp_vec(P_F, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, o, exp_vec(P_F, 1'b0, 1'b0));
      end
    end
    $display("test_reset: %0d checks so far", checks);
  endtask

  task automatic test_add();
    apply_reset();
    exec_instr(T_RTYPE, 3'b000, 0, 0);
    one_cycle(P_F, 1'b0, 1'b0);  // back in FETCH on cycle 5
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL add cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    $display("test_add: %0d cycles observed", obs_q.size());
  endtask

  task automatic test_lh_wait();
    apply_reset();
    exec_instr(T_LOAD, 3'b001, 0, 3);
    one_cycle(P_F, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() !== 9) begin
      errors++;
      $display("FAIL lh length: got %0d required 9", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL lh cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    $display("test_lh_wait: %0d cycles observed", obs_q.size());
  endtask

  task automatic test_bne_sh();
    apply_reset();
    exec_instr(T_BRANCH, 3'b001, 0, 0);
    exec_instr(T_STORE, 3'b001, 0, 0);
    exec_instr(T_ITYPE, 3'b111, 0, 0);
    one_cycle(P_F, 1'b0, 1'b0);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bne_sh_andi cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    $display("test_bne_sh: %0d cycles observed", obs_q.size());
  endtask

  task automatic test_timeout();
    // Fetch never acknowledged: HALT after TO cycles, fault held.
    apply_reset();
    cur_op = T_RTYPE; cur_f3 = 3'b000;
    repeat (TO) one_cycle(P_F, 1'b0, 1'b0);
    repeat (3) one_cycle(P_HALT, 1'($urandom_range(0, 1)), 1'b1);
    // Reset clears fault; ack on the last allowed cycle wins.
    apply_reset();
    repeat (TO - 1) one_cycle(P_F, 1'b0, 1'b0);
    one_cycle(P_F, 1'b1, 1'b0);
    one_cycle(P_D, 1'b0, 1'b0);
    // Data read stalls in MEM_RD.
    apply_reset();
    cur_op = T_LOAD; cur_f3 = 3'b001;
    one_cycle(P_F, 1'b1, 1'b0);
    one_cycle(P_D, 1'b0, 1'b0);
    one_cycle(P_MA, 1'b0, 1'b0);
    repeat (TO) one_cycle(P_MR, 1'b0, 1'b0);
    repeat (2) one_cycle(P_HALT, 1'b1, 1'b1);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    $display("test_timeout: %0d cycles observed", obs_q.size());
  endtask

  task automatic test_reset_mid();
    logic [14:0] o;
    apply_reset();
    cur_op = T_STORE; cur_f3 = 3'b001;
    one_cycle(P_F, 1'b1, 1'b0);
    one_cycle(P_D, 1'b0, 1'b0);
    one_cycle(P_MA, 1'b0, 1'b0);
    one_cycle(P_MW, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    o = obs_vec();
    checks++;
    if (o !== exp_vec(P_F, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid after reset: got %b expected %b", o, exp_vec(P_F, 1'b0, 1'b0));
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    $display("test_reset_mid: store abandoned");
  endtask

  task automatic test_illegal();
    apply_reset();
    exec_instr(7'b1111111, 3'($urandom_range(0, 7)), 0, 0);
`ifdef ILLEGAL_TRAP_EN
    repeat (2) one_cycle(P_HALT, 1'b1, 1'b1);
`else
    one_cycle(P_F, 1'b0, 1'b0);
`endif
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    $display("test_illegal: %0d cycles observed", obs_q.size());
  endtask

  task automatic test_random();
    logic [6:0] ill_op[6];
    logic [2:0] ill_f3[6];
    logic [6:0] op;
    logic [2:0] f3;
    int k;
    int j;
    ill_op = '{7'b1111111, T_LOAD, T_STORE, T_ITYPE, T_BRANCH, 7'b0110111};
    ill_f3 = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b001};
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: begin op = T_LOAD;   f3 = 3'b001; end
        1: begin op = T_STORE;  f3 = 3'b001; end
        2: begin op = T_RTYPE;  f3 = 3'b000; end
        3: begin op = T_RTYPE;  f3 = 3'b110; end
        4: begin op = T_RTYPE;  f3 = 3'b001; end
        5: begin op = T_ITYPE;  f3 = 3'b111; end
        6: begin op = T_BRANCH; f3 = 3'b001; end
        default: begin
          j = $urandom_range(0, 5);
          op = ill_op[j];
          f3 = ill_f3[j];
        end
      endcase
      obs_q.delete();
      exp_q.delete();
      exec_instr(op, f3, -1, -1);
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random instr %0d op %b f3 %b cycle %0d: got %b expected %b",
                   n, op, f3, i, obs_q[i], exp_q[i]);
        end
      end
      $display("random instr %0d: op %b f3 %b, %0d cycles", n, op, f3, obs_q.size());
      if (plan_q[plan_q.size() - 1] == P_HALT) apply_reset();
    end
  endtask

  initial begin
    bus.opcode = 7'h0;
    bus.funct3 = 3'h0;
    bus.mem_ready = 1'b1;
    cur_op = 7'h0;
    cur_f3 = 3'h0;
    test_reset();
    test_add();
    test_lh_wait();
    test_bne_sh();
    test_timeout();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
